// File: rtl/impact_voice_scheduler.sv
// impact_voice_scheduler: round-robin arbiter sharing one resonator voice among impact requesters (optional VOICE_DECAY_EN ages pending requests per frame)
module impact_voice_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int HOLDOFF      = 3,
    parameter int TENSION_BASE = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   sample_tick,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [3*NUM_SRC-1:0]   req_impact,
    input  logic                   mute,
    output logic [NUM_SRC-1:0]     ack,
    output logic [2:0]             trigger,
    output logic [3:0]             tension,
    output logic [1:0]             active_src,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

    state_t     state, state_d;
    logic [2:0] pending   [NUM_SRC];
    logic [2:0] pending_d [NUM_SRC];
    logic [1:0] ptr, gsel;
    logic [2:0] gval, trig_reg;
    logic [3:0] hold;
    logic       any_pend, grant;

    assign trigger = (state == ARMED) ? trig_reg : 3'd0;
    assign busy    = state != IDLE;
    assign grant   = (state == IDLE) && any_pend && !mute;

    // first nonzero pending entry searching upward from the round-robin pointer
    always_comb begin
        any_pend = 1'b0;
        gsel     = ptr;
        gval     = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!any_pend && pending[(int'(ptr) + k) % NUM_SRC] != 3'd0) begin
                any_pend = 1'b1;
                gsel     = 2'((int'(ptr) + k) % NUM_SRC);
                gval     = pending[(int'(ptr) + k) % NUM_SRC];
            end
        end
    end

    // voice FSM: grant, wait for the resonator to sample, then frame hold-off
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = grant ? ARMED : IDLE;
            ARMED:   state_d = mute ? IDLE : sample_tick ? ((HOLDOFF == 0) ? IDLE : HOLD) : ARMED;
            HOLD:    state_d = (frame_tick && hold <= 4'd1) ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // pending update: grant clears first, then optional decay, then max-merge of new request; mute wipes all
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_d[i] = (grant && gsel == 2'(i)) ? 3'd0 : pending[i];
`ifdef VOICE_DECAY_EN
            if (frame_tick && pending_d[i] != 3'd0) pending_d[i] = pending_d[i] - 3'd1;
`else
            pending_d[i] = pending_d[i];
`endif
            if (req[i] && req_impact[3*i +: 3] > pending_d[i]) pending_d[i] = req_impact[3*i +: 3];
            if (mute) pending_d[i] = 3'd0;
        end
    end

    // state, pending, grant bookkeeping and hold-off counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            trig_reg   <= 3'd0;
            ack        <= '0;
            tension    <= 4'(TENSION_BASE);
            active_src <= 2'd0;
            hold       <= 4'd0;
            for (int i = 0; i < NUM_SRC; i++) pending[i] <= 3'd0;
        end else begin
            state <= state_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                pending[i] <= pending_d[i];
                ack[i]     <= req[i] && (req_impact[3*i +: 3] != 3'd0) && !mute;
            end
            if (grant) begin
                trig_reg   <= gval;
                tension    <= 4'(TENSION_BASE + int'(gsel));
                active_src <= gsel;
                ptr        <= 2'((int'(gsel) + 1) % NUM_SRC);
            end
            if (state == ARMED && !mute && sample_tick) hold <= 4'(HOLDOFF);
            else if (state == HOLD && frame_tick) hold <= hold - 4'd1;
        end
    end
endmodule

// File: tb/tb_impact_voice_scheduler.sv
// tb_impact_voice_scheduler: directed checks of grant order, merging, mute and hold-off timing
module tb_impact_voice_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        sample_tick = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_impact = '0;
    logic        mute = 1'b0;
    logic [3:0]  ack;
    logic [2:0]  trigger;
    logic [3:0]  tension;
    logic [1:0]  active_src;
    logic        busy;
    int nvec = 0;
    int nerr = 0;

    impact_voice_scheduler #(.NUM_SRC(4), .HOLDOFF(3), .TENSION_BASE(6)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .sample_tick(sample_tick),
        .req(req), .req_impact(req_impact), .mute(mute), .ack(ack),
        .trigger(trigger), .tension(tension), .active_src(active_src), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic consume();
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_impact = '0;
        mute = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (trigger !== 3'd0) begin nerr++; $display("FAIL reset_trigger got %0d want 0", trigger); end
        nvec++; if (ack !== 4'd0) begin nerr++; $display("FAIL reset_ack got %b want 0000", ack); end
        nvec++; if (tension !== 4'd6) begin nerr++; $display("FAIL reset_tension got %0d want 6", tension); end
        nvec++; if (active_src !== 2'd0) begin nerr++; $display("FAIL reset_active got %0d want 0", active_src); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %0d want 0", busy); end
    endtask

    task automatic test_single();
        req = 4'b0100;
        req_impact = 12'b000_101_000_000;
        tick();
        req = '0;
        req_impact = '0;
        nvec++; if (ack !== 4'b0100) begin nerr++; $display("FAIL single_ack got %b want 0100", ack); end
        nvec++; if (trigger !== 3'd0) begin nerr++; $display("FAIL single_trig_early got %0d want 0", trigger); end
        tick();
        nvec++; if (trigger !== 3'd5) begin nerr++; $display("FAIL single_trig got %0d want 5", trigger); end
        nvec++; if (tension !== 4'd8) begin nerr++; $display("FAIL single_tension got %0d want 8", tension); end
        nvec++; if (active_src !== 2'd2) begin nerr++; $display("FAIL single_active got %0d want 2", active_src); end
        nvec++; if (ack !== 4'b0000) begin nerr++; $display("FAIL single_ack_pulse got %b want 0000", ack); end
        tick();
        nvec++; if (trigger !== 3'd5) begin nerr++; $display("FAIL single_trig_held got %0d want 5", trigger); end
        consume();
        nvec++; if (trigger !== 3'd0) begin nerr++; $display("FAIL single_trig_after got %0d want 0", trigger); end
        for (int f = 1; f <= 3; f++) begin
            pulse_frame();
            nvec++; if (busy !== (f < 3)) begin nerr++; $display("FAIL single_hold_f%0d busy got %0d want %0d", f, busy, f < 3); end
        end
        nvec++; if (tension !== 4'd8) begin nerr++; $display("FAIL single_tension_kept got %0d want 8", tension); end
    endtask

    task automatic test_merge();
        req = 4'b1000;
        req_impact = 12'b001_000_000_000;
        tick();
        req = '0;
        tick();
        nvec++; if (trigger !== 3'd1 || active_src !== 2'd3) begin nerr++; $display("FAIL merge_busy_grant got trig %0d src %0d want trig 1 src 3", trigger, active_src); end
        req = 4'b0001;
        req_impact = 12'b000_000_000_011;
        tick();
        nvec++; if (ack !== 4'b0001) begin nerr++; $display("FAIL merge_ack1 got %b want 0001", ack); end
        req_impact = 12'b000_000_000_110;
        tick();
        nvec++; if (ack !== 4'b0001) begin nerr++; $display("FAIL merge_ack2 got %b want 0001", ack); end
        req = '0;
        req_impact = '0;
        consume();
        for (int f = 0; f < 3; f++) pulse_frame();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL merge_idle got %0d want 0", busy); end
        tick();
        nvec++; if (trigger !== 3'd6) begin nerr++; $display("FAIL merge_trig got %0d want 6", trigger); end
        nvec++; if (active_src !== 2'd0 || tension !== 4'd6) begin nerr++; $display("FAIL merge_src got src %0d ten %0d want src 0 ten 6", active_src, tension); end
        consume();
        for (int f = 0; f < 3; f++) pulse_frame();
        tick();
        tick();
        nvec++; if (busy !== 1'b0 || trigger !== 3'd0) begin nerr++; $display("FAIL merge_single got busy %0d trig %0d want 0 0", busy, trigger); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        req_impact = 12'b100_100_100_100;
        tick();
        req = '0;
        req_impact = '0;
        nvec++; if (ack !== 4'b1111) begin nerr++; $display("FAIL rr_ack got %b want 1111", ack); end
        for (int g = 0; g < 4; g++) begin
            tick();
            nvec++; if (trigger !== 3'd4 || active_src !== 2'(g) || tension !== 4'(6 + g)) begin
                nerr++; $display("FAIL rr_grant%0d got trig %0d src %0d ten %0d want 4 %0d %0d", g, trigger, active_src, tension, g, 6 + g);
            end
            consume();
            nvec++; if (trigger !== 3'd0 || busy !== 1'b1) begin nerr++; $display("FAIL rr_hold%0d got trig %0d busy %0d want 0 1", g, trigger, busy); end
            for (int f = 0; f < 3; f++) pulse_frame();
        end
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rr_done got busy %0d want 0", busy); end
    endtask

    task automatic test_mute();
        req = 4'b0010;
        req_impact = 12'b000_000_111_000;
        tick();
        req = '0;
        req_impact = '0;
        tick();
        nvec++; if (trigger !== 3'd7 || active_src !== 2'd1) begin nerr++; $display("FAIL mute_armed got trig %0d src %0d want 7 1", trigger, active_src); end
        req = 4'b0100;
        req_impact = 12'b000_011_000_000;
        tick();
        req = 4'b0001;
        req_impact = 12'b000_000_000_101;
        mute = 1'b1;
        tick();
        req = '0;
        req_impact = '0;
        mute = 1'b0;
        nvec++; if (trigger !== 3'd0) begin nerr++; $display("FAIL mute_trig got %0d want 0", trigger); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mute_busy got %0d want 0", busy); end
        nvec++; if (ack !== 4'b0000) begin nerr++; $display("FAIL mute_ack got %b want 0000", ack); end
        nvec++; if (tension !== 4'd7 || active_src !== 2'd1) begin nerr++; $display("FAIL mute_hold got ten %0d src %0d want 7 1", tension, active_src); end
        tick();
        tick();
        nvec++; if (busy !== 1'b0 || trigger !== 3'd0) begin nerr++; $display("FAIL mute_cleared got busy %0d trig %0d want 0 0", busy, trigger); end
    endtask

    task automatic test_zero_and_clear();
        req = 4'b0010;
        req_impact = 12'b000_000_000_000;
        tick();
        req = '0;
        nvec++; if (ack !== 4'b0000) begin nerr++; $display("FAIL zero_ack got %b want 0000", ack); end
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL zero_busy got %0d want 0", busy); end
        req = 4'b0010;
        req_impact = 12'b000_000_101_000;
        tick();
        req_impact = 12'b000_000_010_000;
        tick();
        req = '0;
        req_impact = '0;
        nvec++; if (trigger !== 3'd5 || active_src !== 2'd1) begin nerr++; $display("FAIL clear_first got trig %0d src %0d want 5 1", trigger, active_src); end
        nvec++; if (ack !== 4'b0010) begin nerr++; $display("FAIL clear_ack got %b want 0010", ack); end
        consume();
        for (int f = 0; f < 3; f++) pulse_frame();
        tick();
        nvec++; if (trigger !== 3'd2 || active_src !== 2'd1) begin nerr++; $display("FAIL clear_second got trig %0d src %0d want 2 1", trigger, active_src); end
        consume();
        for (int f = 0; f < 3; f++) pulse_frame();
    endtask

    task automatic test_pending_age();
        req = 4'b0001;
        req_impact = 12'b000_000_000_001;
        tick();
        req = '0;
        req_impact = '0;
        tick();
        nvec++; if (trigger !== 3'd1 || active_src !== 2'd0) begin nerr++; $display("FAIL age_grant got trig %0d src %0d want 1 0", trigger, active_src); end
        consume();
        req = 4'b1000;
        req_impact = 12'b010_000_000_000;
        tick();
        req = '0;
        req_impact = '0;
        for (int f = 0; f < 3; f++) pulse_frame();
        tick();
`ifdef VOICE_DECAY_EN
        nvec++; if (busy !== 1'b0 || trigger !== 3'd0 || active_src !== 2'd0) begin
            nerr++; $display("FAIL decay_drop got busy %0d trig %0d src %0d want 0 0 0", busy, trigger, active_src);
        end
`else
        nvec++; if (trigger !== 3'd2 || active_src !== 2'd3) begin nerr++; $display("FAIL persist_grant got trig %0d src %0d want 2 3", trigger, active_src); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_merge();
        test_round_robin();
        test_mute();
        test_zero_and_clear();
        test_pending_age();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
